key_cmd_queue: RTL
==================

KEY_CMD_QUEUE -- requirements
Module: key_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the drop counter.
REQ-003 SHALL have port clk  input  1  system clock; one clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port pulse_left  input  1  single-cycle debounced key pulse from the edge stage.
REQ-006 SHALL have port pulse_right  input  1  as above, right key.
REQ-007 SHALL have port pulse_rotate  input  1  as above, rotate key.
REQ-008 SHALL have port pulse_drop  input  1  as above, hard-drop key.
REQ-009 SHALL have port flush  input  1  discard all pending and queued commands (e.g. new piece or game over).
REQ-010 SHALL have port cmd_valid  output  1  head-of-queue command present.
REQ-011 SHALL have port cmd_code  output  3  head command: 1=LEFT, 2=RIGHT, 3=ROTATE, 4=DROP; 0 when cmd_valid low.
REQ-012 SHALL have port cmd_ready  input  1  game logic accepts head command.
REQ-013 SHALL have port drop_cnt  output  CNT_W  saturating count of key events lost to coalescing.

Function
REQ-014 SHALL hold one sticky pending bit per key; a pulse sets its bit at the next edge.
REQ-015 SHALL, each cycle the FIFO is not full, grant exactly one set pending bit, fixed priority DROP > ROTATE > LEFT > RIGHT, push its code, and clear that bit.
REQ-016 SHALL give latency of exactly 2 edges from a pulse-high sample to cmd_valid high, given an empty FIFO and no higher-priority pending.
REQ-017 SHALL keep a pending bit set if its pulse arrives in the same cycle it is granted (new request, not counted as dropped).
REQ-018 SHALL increment drop_cnt when a pulse arrives while its pending bit is already set and not being granted; saturate at all-ones.
REQ-019 SHALL pop the head when cmd_valid and cmd_ready are both high at an edge; cmd_code SHALL stay stable while cmd_valid high and cmd_ready low.
REQ-020 SHALL allow simultaneous push and pop when full; count unchanged, no loss.
REQ-021 SHALL hold pending bits without loss while the FIFO is full; no pushes are made.
REQ-022 SHALL present FIFO output registered: cmd_valid = not empty, cmd_code = head entry, no combinational path from pulse_* to outputs.
REQ-023 SHALL ignore cmd_ready while cmd_valid is low.
REQ-024 SHALL, on flush high at an edge, empty the FIFO and clear all pending bits; flush overrides pulses, push and pop in that cycle; drop_cnt is unaffected.
REQ-025 SHALL wrap read/write pointers modulo DEPTH, using a count of width clog2(DEPTH)+1 for full/empty.

Reset
REQ-026 SHALL, on rst high at an edge, clear pending bits, pointers and count, set cmd_valid=0, cmd_code=0, drop_cnt=0.
REQ-027 SHALL ignore pulses sampled in a reset cycle; reset mid-operation discards all queued commands.

Structure
REQ-028 SHALL place command codes CMD_NONE/LEFT/RIGHT/ROTATE/DROP in the shared Tetris definitions package, used by this block and game logic.
REQ-029 SHALL implement the queue as one sub-module cmd_fifo (synchronous, parameterised width/depth, registered output); arbiter and pending logic in the top.

Verification
REQ-030 SHALL cover: single pulse_left, cmd_ready=1 -> cmd_valid high 2 edges later with cmd_code=1 for exactly 1 cycle.
REQ-031 SHALL cover: all four pulses in one cycle, cmd_ready=1 -> codes 4,3,1,2 on consecutive cycles, drop_cnt=0.
REQ-032 SHALL cover: cmd_ready=0, 6 rotate/left/right/drop pulses spaced 3 cycles -> FIFO holds 4, remaining held pending, released in priority order after cmd_ready=1.
REQ-033 SHALL cover: cmd_ready=0, FIFO full, three pulse_left -> one pending, drop_cnt=2; saturation check with 300 repeats -> drop_cnt=255.
REQ-034 SHALL cover: flush asserted with 3 queued and pulse_drop in the same cycle -> cmd_valid=0 next cycle, no DROP emitted.
REQ-035 SHALL cover: rst asserted mid-stream with pulses active -> all outputs 0 next cycle, first post-reset pulse gives 2-edge latency.

Source files
------------

// File: rtl/key_cmd_queue_pkg.sv
// Shared Tetris command definitions: command codes, key indices and the
// fixed-priority grant picker used by the key command queue.
package key_cmd_queue_pkg;

    localparam int CMD_W    = 3;
    localparam int NUM_KEYS = 4;

    // Bit positions of each key inside the pulse/pending vectors
    localparam int KEY_LEFT   = 0;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_ROTATE = 2;
    localparam int KEY_DROP   = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE   = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_ROTATE = 3'd3,
        CMD_DROP   = 3'd4
    } cmd_code_e;

    typedef struct packed {
        logic [NUM_KEYS-1:0] onehot;
        cmd_code_e           code;
    } grant_t;

    // Fixed priority DROP > ROTATE > LEFT > RIGHT
    function automatic grant_t pick_grant(input logic [NUM_KEYS-1:0] pend);
        grant_t g;
        g.onehot = '0;
        g.code   = CMD_NONE;
        if (pend[KEY_DROP]) begin
            g.onehot[KEY_DROP] = 1'b1;
            g.code             = CMD_DROP;
        end else if (pend[KEY_ROTATE]) begin
            g.onehot[KEY_ROTATE] = 1'b1;
            g.code               = CMD_ROTATE;
        end else if (pend[KEY_LEFT]) begin
            g.onehot[KEY_LEFT] = 1'b1;
            g.code             = CMD_LEFT;
        end else if (pend[KEY_RIGHT]) begin
            g.onehot[KEY_RIGHT] = 1'b1;
            g.code              = CMD_RIGHT;
        end
        return g;
    endfunction

endpackage

// File: rtl/key_cmd_queue_cmd_fifo.sv
// Synchronous FIFO for game commands. Output is driven only from state
// registers (storage + read pointer + count), so nothing on the write side
// reaches rdata/empty combinationally.
module cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];

    // A push into a full FIFO is allowed only when the head leaves the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^AW)
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage; contents past the count are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/key_cmd_queue.sv
// Key command queue: latches debounced key pulses into sticky pending bits,
// arbitrates them one per cycle into a command FIFO, and counts key events
// lost because the same key was already waiting.
module key_cmd_queue
    import key_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_left,
    input  logic             pulse_right,
    input  logic             pulse_rotate,
    input  logic             pulse_drop,
    input  logic             flush,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd_code,
    input  logic             cmd_ready,
    output logic [CNT_W-1:0] drop_cnt
);
    logic [NUM_KEYS-1:0] pulse, pending, grant, drop_ev;
    grant_t              pick;
    logic                fifo_empty, fifo_full, push, pop;
    logic [2:0]          n_drop;
    logic [CNT_W:0]      cnt_sum;

    assign pulse = {pulse_drop, pulse_rotate, pulse_right, pulse_left};

    // Grant only when there is room; a full FIFO leaves pending bits untouched
    assign pick  = pick_grant(pending);
    assign grant = fifo_full ? '0 : pick.onehot;
    assign push  = |grant;
    assign pop   = cmd_valid && cmd_ready;

    // A pulse is lost only if its key is still waiting and not leaving this cycle
    assign drop_ev = pulse & pending & ~grant;

    // Number of lost events this cycle (up to one per key)
    always_comb begin
        n_drop = '0;
        for (int k = 0; k < NUM_KEYS; k++) n_drop = n_drop + {2'b00, drop_ev[k]};
    end

    assign cnt_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

    // Pending bits and saturating loss counter; flush clears requests but keeps statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            pending  <= '0;
        end else begin
            pending  <= pulse | (pending & ~grant);
            drop_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (pick.code),
        .pop   (pop),
        .empty (fifo_empty),
        .full  (fifo_full),
        .rdata (cmd_code)
    );

    assign cmd_valid = !fifo_empty;

endmodule
